// File: rtl/traffic_checker.sv
// traffic_checker: passive intersection safety monitor; TRAFFIC_CHECKER_DWELL_EN adds yellow/blink dwell checks (code 6)
module traffic_checker (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic [1:0] i_n_car,
  input  logic [1:0] i_s_car,
  input  logic [1:0] i_e_car,
  input  logic [1:0] i_w_car,
  input  logic [1:0] i_n_ped,
  input  logic [1:0] i_s_ped,
  input  logic [1:0] i_e_ped,
  input  logic [1:0] i_w_ped,
  input  logic [6:0] i_cycle,
  output logic       o_lock,
  output logic       o_err,
  output logic [2:0] o_err_code,
  output logic [6:0] o_err_cycle,
  output logic [7:0] o_err_cnt,
  output logic       o_period_ok
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;
  state_t state, state_nx;
  logic [3:0][1:0] car, ped, pcar, pped;
  logic [6:0] pcyc;
  logic [7:1] e;
  logic [2:0] code;
  logic run, err_now, lock_entry, wrap, clean, dwell_err;
  function automatic logic car_ok(input logic [1:0] p, input logic [1:0] c);
    return p == c || {p, c} inside {4'b0110, 4'b1011, 4'b1110, 4'b1000, 4'b0001};
  endfunction
  function automatic logic ped_ok(input logic [1:0] p, input logic [1:0] c);
    return p == c || {p, c} inside {4'b0001, 4'b0110, 4'b1000};
  endfunction
  assign car = {i_n_car, i_s_car, i_e_car, i_w_car};
  assign ped = {i_n_ped, i_s_ped, i_e_ped, i_w_ped};
  assign run = state == S_RUN;
  assign lock_entry = state == S_ARM && i_cycle == 7'd1;
  assign wrap = run && pcyc == 7'd68 && i_cycle == 7'd1;
  assign o_lock = run;
  always_comb begin
    e = '0;
    for (int d = 0; d < 4; d++) begin
      e[1] = e[1] | (ped[d] == 2'b11);
      e[3] = e[3] | (ped[d] != 2'b00 && car[d] != 2'b00);
      e[4] = e[4] | !car_ok(pcar[d], car[d]);
      e[5] = e[5] | !ped_ok(pped[d], ped[d]);
    end
    e[2] = (car[3] != 2'b00 || car[2] != 2'b00) && (car[1] != 2'b00 || car[0] != 2'b00);
    e[6] = dwell_err;
    e[7] = i_cycle == 7'd0 || i_cycle > 7'd68 ||
           (i_cycle != pcyc + 7'd1 && !(pcyc == 7'd68 && i_cycle == 7'd1));
    e[3:1] = state == S_IDLE ? 3'd0 : e[3:1];
    e[7:4] = run ? e[7:4] : 4'd0;
  end
  assign err_now = |e;
  assign code = e[1] ? 3'd1 : e[2] ? 3'd2 : e[3] ? 3'd3 : e[4] ? 3'd4 :
                e[5] ? 3'd5 : e[6] ? 3'd6 : e[7] ? 3'd7 : 3'd0;
  always_comb begin
    state_nx = state == S_IDLE ? S_ARM : lock_entry ? S_RUN : (run && e[7]) ? S_ARM : state;
  end
`ifdef TRAFFIC_CHECKER_DWELL_EN
  logic [3:0][2:0] cdw, pdw;
  logic [3:0] cdv, pdv;
  always_comb begin
    dwell_err = 1'b0;
    for (int d = 0; d < 4; d++)
      dwell_err = dwell_err |
                  (cdv[d] && pcar[d] == 2'b10 && car[d] != 2'b10 && cdw[d] != 3'd2) |
                  (pdv[d] && pped[d] == 2'b10 && ped[d] != 2'b10 && pdw[d] != 3'd6);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cdw <= '0;
      pdw <= '0;
      cdv <= '0;
      pdv <= '0;
    end else
      for (int d = 0; d < 4; d++) begin
        cdw[d] <= !run ? 3'd0 : car[d] != pcar[d] ? 3'd1 : cdw[d] == 3'd7 ? 3'd7 : cdw[d] + 3'd1;
        pdw[d] <= !run ? 3'd0 : ped[d] != pped[d] ? 3'd1 : pdw[d] == 3'd7 ? 3'd7 : pdw[d] + 3'd1;
        cdv[d] <= run && (cdv[d] || car[d] != pcar[d]);
        pdv[d] <= run && (pdv[d] || ped[d] != pped[d]);
      end
`else
  assign dwell_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      pcar <= '0;
      pped <= '0;
      pcyc <= '0;
      o_err <= 1'b0;
      o_err_code <= '0;
      o_err_cycle <= '0;
      o_err_cnt <= '0;
      o_period_ok <= 1'b0;
      clean <= 1'b0;
    end else begin
      state <= state_nx;
      pcar <= car;
      pped <= ped;
      pcyc <= i_cycle;
      o_err <= err_now || (o_err && !i_clr);
      o_err_code <= (err_now && (!o_err || i_clr)) ? code : i_clr ? 3'd0 : o_err_code;
      o_err_cycle <= (err_now && (!o_err || i_clr)) ? i_cycle : i_clr ? 7'd0 : o_err_cycle;
      o_err_cnt <= err_now ? (i_clr ? 8'd1 : o_err_cnt == 8'hff ? o_err_cnt : o_err_cnt + 8'd1) :
                   i_clr ? 8'd0 : o_err_cnt;
      o_period_ok <= wrap && clean && !err_now;
      clean <= i_clr ? 1'b0 : lock_entry ? !err_now : wrap ? 1'b1 : (run && err_now) ? 1'b0 : clean;
    end
endmodule

// File: tb/tb_traffic_checker.sv
// tb_traffic_checker: directed-vector bench for traffic_checker
module tb_traffic_checker;
  logic clk = 1'b0, rst = 1'b1, i_clr = 1'b0;
  logic [1:0] i_n_car = '0, i_s_car = '0, i_e_car = '0, i_w_car = '0;
  logic [1:0] i_n_ped = '0, i_s_ped = '0, i_e_ped = '0, i_w_ped = '0;
  logic [6:0] i_cycle = '0;
  logic o_lock, o_err, o_period_ok;
  logic [2:0] o_err_code;
  logic [6:0] o_err_cycle;
  logic [7:0] o_err_cnt;
  int checks = 0, errors = 0, cur = 0, pulses = 0;
  always #5 clk = ~clk;
  traffic_checker dut (
    .clk(clk), .rst(rst), .i_clr(i_clr),
    .i_n_car(i_n_car), .i_s_car(i_s_car), .i_e_car(i_e_car), .i_w_car(i_w_car),
    .i_n_ped(i_n_ped), .i_s_ped(i_s_ped), .i_e_ped(i_e_ped), .i_w_ped(i_w_ped),
    .i_cycle(i_cycle), .o_lock(o_lock), .o_err(o_err), .o_err_code(o_err_code),
    .o_err_cycle(o_err_cycle), .o_err_cnt(o_err_cnt), .o_period_ok(o_period_ok)
  );
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] sched(input int c);
    logic [1:0] nc, ec, np, ep;
    nc = c <= 20 ? 2'b01 : c <= 22 ? 2'b10 : 2'b00;
    ec = c <= 24 ? 2'b00 : c <= 40 ? 2'b01 : c <= 42 ? 2'b10 : c <= 50 ? 2'b11 : c <= 52 ? 2'b10 : 2'b00;
    np = (c >= 23 && c <= 40) ? 2'b01 : (c >= 41 && c <= 46) ? 2'b10 : 2'b00;
    ep = (c >= 53 && c <= 62) ? 2'b01 : c >= 63 ? 2'b10 : 2'b00;
    return {nc, nc, ec, ec, np, np, ep, ep};
  endfunction
  task automatic apply(input int c);
    {i_n_car, i_s_car, i_e_car, i_w_car, i_n_ped, i_s_ped, i_e_ped, i_w_ped} = sched(c);
    i_cycle = 7'(c);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic adv;
    cur = cur == 68 ? 1 : cur + 1;
    apply(cur);
  endtask
  task automatic step;
    adv;
    tick;
  endtask
  task automatic run_to(input int c);
    while (cur != c) step;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_lock"}, o_lock, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_code"}, o_err_code, 0);
    check({tag, "_cycle"}, o_err_cycle, 0);
    check({tag, "_cnt"}, o_err_cnt, 0);
    check({tag, "_pok"}, o_period_ok, 0);
  endtask
  initial begin
    tick;
    check_zero("reset");
    rst = 1'b0;
    tick;
    tick;
    check("arm_nolock", o_lock, 0);
    for (int r = 0; r < 3; r++)
      for (int c = 1; c <= 68; c++) begin
        step;
        pulses += int'(o_period_ok);
        check("clean_lock", o_lock, 1);
        check("clean_err", o_err, 0);
      end
    check("clean_pulses", pulses, 2);
    run_to(9);
    adv;
    i_e_car = 2'b01;
    tick;
    check("conf_err", o_err, 1);
    check("conf_code", o_err_code, 2);
    check("conf_cycle", o_err_cycle, 10);
    check("conf_cnt", o_err_cnt, 1);
    step;
    check("first_wins_code", o_err_code, 2);
    check("first_wins_cnt", o_err_cnt, 2);
    adv;
    i_clr = 1'b1;
    tick;
    i_clr = 1'b0;
    check("clr_err", o_err, 0);
    check("clr_code", o_err_code, 0);
    check("clr_cnt", o_err_cnt, 0);
    run_to(29);
    adv;
    i_n_ped = 2'b11;
    i_e_car = 2'b01;
    tick;
    check("simul_code", o_err_code, 1);
    check("simul_cnt", o_err_cnt, 1);
    check("simul_cycle", o_err_cycle, 30);
    for (int k = 0; k < 299; k++) begin
      adv;
      i_n_ped = 2'b11;
      tick;
    end
    check("sat_cnt", o_err_cnt, 255);
    check("sat_code", o_err_code, 1);
    check("sat_lock", o_lock, 1);
    step;
    run_to(18);
    adv;
    i_clr = 1'b1;
    tick;
    i_clr = 1'b0;
    check("clr2_err", o_err, 0);
    run_to(20);
    cur = 25;
    apply(20);
    i_cycle = 7'd25;
    tick;
    check("jump_code", o_err_code, 7);
    check("jump_cycle", o_err_cycle, 25);
    check("jump_lock", o_lock, 0);
    run_to(68);
    check("jump_still_unlocked", o_lock, 0);
    step;
    check("relock", o_lock, 1);
    check("relock_cnt", o_err_cnt, 1);
    adv;
    i_clr = 1'b1;
    tick;
    i_clr = 1'b0;
    run_to(22);
    adv;
    {i_n_car, i_s_car, i_n_ped, i_s_ped} = {2'b10, 2'b10, 2'b00, 2'b00};
    tick;
    check("dwell_hold_err", o_err, 0);
    step;
`ifdef TRAFFIC_CHECKER_DWELL_EN
    check("dwell_err", o_err, 1);
    check("dwell_code", o_err_code, 6);
    check("dwell_cycle", o_err_cycle, 24);
`else
    check("dwell_off_err", o_err, 0);
    check("dwell_off_code", o_err_code, 0);
`endif
    run_to(4);
    adv;
    i_n_car = 2'b00;
    i_clr = 1'b1;
    tick;
    i_clr = 1'b0;
    check("clrerr_err", o_err, 1);
    check("clrerr_code", o_err_code, 4);
    check("clrerr_cnt", o_err_cnt, 1);
    check("clrerr_cycle", o_err_cycle, 5);
    run_to(30);
    check("pre_rst_lock", o_lock, 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    tick;
    check("rst_hold_lock", o_lock, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_checker.md
# traffic_checker

Passive safety monitor for the four-direction intersection. It samples the per-direction car and pedestrian signal codes plus the shared cycle counter every clock and checks each sample against the intersection rules: encoding legality, cross-traffic conflicts, pedestrian-versus-car conflicts, legal transitions, phase dwell and cycle continuity. It sits beside the signal controller top-level as its consumer and reports sticky, first-error-wins diagnostics.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_clr` in 1: synchronous clear of the sticky error outputs and counters.
- `i_n_car`, `i_s_car`, `i_e_car`, `i_w_car` in 2 each: car codes. RED=00, GREEN=01, YELLOW=10, LEFT=11.
- `i_n_ped`, `i_s_ped`, `i_e_ped`, `i_w_ped` in 2 each: pedestrian codes. RED=00, GREEN=01, BLINK=10, 11 is illegal.
- `i_cycle` in 7: controller cycle counter; legal range is 1..68.
- `o_lock` out 1: high when the checker is in S_RUN.
- `o_err` out 1: sticky; set by any error.
- `o_err_code` out 3: code of the first error. 0 means none.
- `o_err_cycle` out 7: `i_cycle` value at the first error.
- `o_err_cnt` out 8: count of clock cycles with at least one error; saturates at 255.
- `o_period_ok` out 1: one-cycle pulse marking a clean full period.

## Operation
- **FSM states:**
  - S_IDLE → S_ARM on the first clock after reset.
  - S_ARM → S_RUN when `i_cycle`==1.
  - S_RUN → S_ARM on a code-7 error.
- **History registers:** each clock the checker registers every input as "previous" values, which are used for the transition checks.
- **Checks while in S_RUN:**
  - Code 1: any pedestrian code is 11.
  - Code 2: (N or S car ≠ RED) while (E or W car ≠ RED).
  - Code 3: a direction's pedestrian code ≠ RED while that same direction's car ≠ RED.
  - Code 4: illegal car transition. Legal transitions are: hold; GREEN→YELLOW; YELLOW→LEFT; LEFT→YELLOW; YELLOW→RED; RED→GREEN.
  - Code 5: illegal pedestrian transition. Legal transitions are: hold; RED→GREEN; GREEN→BLINK; BLINK→RED.
  - Code 6: dwell violation (only when the configuration macro is defined; see Configuration).
  - Code 7: `i_cycle` ≠ previous+1, except the wrap 68→1; also `i_cycle`==0 or >68.
- **Checks in S_ARM:** only codes 1, 2 and 3 are evaluated. No transition or dwell history is trusted in this state.
- **Simultaneous errors in one clock:** the lowest code is recorded; `o_err_cnt` increments once.
- **First-error-wins:** `o_err_code` and `o_err_cycle` are written only while `o_err`==0.
- **`o_period_ok`:** pulses on the S_RUN wrap 68→1 if no error occurred since the previous wrap, or since entry to S_RUN.
- **`i_clr`:** clears `o_err`, `o_err_code`, `o_err_cycle`, `o_err_cnt` and the period-clean flag. FSM state and history registers are not affected.
  - If an error occurs in the same cycle as `i_clr`, the error is recorded: `o_err`=1 and `o_err_cnt`=1.

## Timing
- All outputs are registered. A violation present on the inputs before edge k appears on the outputs right after edge k, i.e. 1-cycle latency.
- Reset values of all outputs are 0; FSM = S_IDLE; history registers = 0; dwell counters = 0.
- Reset asserted mid-operation returns the block to S_IDLE immediately (asynchronous). Sticky state is lost.
- `o_lock` rises on the edge that samples `i_cycle`==1 in S_ARM.
- After a code-7 error, `o_lock` falls on the same edge that records the error. Relock happens at the next `i_cycle`==1.
- `o_period_ok` is high for exactly one cycle, after the edge that samples `i_cycle`==1 following `i_cycle`==68.

## Configuration
- **`TRAFFIC_CHECKER_DWELL_EN` defined:**
  - Per-direction 3-bit dwell counters are present.
  - On exit from car YELLOW, the dwell must have been exactly 2 samples; on exit from pedestrian BLINK, exactly 6 samples. Otherwise a code-6 error is raised.
  - Counters reset on each state change and on entry to S_RUN.
  - A dwell that was already in progress at lock time is not checked.
- **Macro undefined:** no dwell counters exist and code 6 is never produced. All other behaviour is identical.

## Test plan
- **Clean run:** reset, then drive a legal 68-cycle sequence three times (N/S following the mode-0 schedule, E/W following mode-1). Required: `o_lock`=1 from the first `i_cycle`==1, `o_err`=0, and `o_period_ok` pulses twice.
- **Conflict:** at `i_cycle`=10, force `i_e_car`=01 while `i_n_car`=01. Required next cycle: `o_err`=1, `o_err_code`=2, `o_err_cycle`=10, `o_err_cnt`=1.
- **Simultaneous errors:** at `i_cycle`=30, force `i_n_ped`=11 and `i_e_car`=01 together. Required: `o_err_code`=1, `o_err_cnt`=1. Hold the fault 300 cycles: `o_err_cnt` saturates at 255 and the code stays 1.
- **Cycle jump:** step `i_cycle` 20→25. Required: `o_err_code`=7, `o_err_cycle`=25, `o_lock`=0. `o_lock` returns to 1 after the next `i_cycle`==1.
- **Dwell (macro defined):** hold N and S car YELLOW for 3 cycles at `i_cycle`=21..23. Required: `o_err_code`=6 on the exit sample. With the macro undefined, the same stimulus gives no error.
- **Clear and reset:** assert `i_clr` coincident with a code-4 error, where N car goes GREEN→RED. Required: `o_err_code`=4, `o_err_cnt`=1. Then assert `rst` mid-period: all outputs go to 0 immediately.
